// File: rtl/ramen_order_sched.sv
// Front-end scheduler for the Ramen kitchen core: round-robin order arbitration,
// single in-flight order, session open/close control and end-of-session totals capture.
module ramen_order_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 open_req,
  input  logic                 close_req,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [2*N_REQ-1:0]   req_type,
  input  logic [N_REQ-1:0]     req_portion,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_success,
  output logic                 core_in_valid,
  output logic                 core_selling,
  output logic                 core_portion,
  output logic [1:0]           core_ramen_type,
  input  logic                 core_out_valid_order,
  input  logic                 core_success,
  input  logic                 core_out_valid_tot,
  input  logic [14:0]          core_total_gain,
  input  logic [27:0]          core_sold_num,
  output logic                 tot_valid,
  output logic [14:0]          tot_gain,
  output logic [27:0]          tot_sold,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, OPEN, ISSUE, WAIT_RSP, CLOSE, DONE} state_t;

  state_t        state, state_nx;
  logic          close_pend;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          take_grant;
  logic [CW-1:0] cnt;
  logic          cnt_expired;

  // Round-robin search starts just after the last granted window.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    idx         = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % N_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    take_grant  = (state == OPEN) && !close_pend && grant_found;
    cnt_expired = (cnt == CW'(TIMEOUT - 1));
    busy        = (state != IDLE);
    req_ready   = '0;
    if (take_grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (open_req) state_nx = OPEN;
      OPEN: begin
        if (close_pend)       state_nx = CLOSE;
        else if (grant_found) state_nx = ISSUE;
      end
      ISSUE:    state_nx = WAIT_RSP;
      WAIT_RSP: if (core_out_valid_order || cnt_expired) state_nx = OPEN;
      CLOSE:    if (core_out_valid_tot || cnt_expired) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      close_pend      <= 1'b0;
      ptr             <= PW'(N_REQ - 1);
      cnt             <= '0;
      rsp_valid       <= '0;
      rsp_success     <= 1'b0;
      core_in_valid   <= 1'b0;
      core_selling    <= 1'b0;
      core_portion    <= 1'b0;
      core_ramen_type <= '0;
      tot_valid       <= 1'b0;
      tot_gain        <= '0;
      tot_sold        <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state         <= state_nx;
      rsp_valid     <= '0;
      rsp_success   <= 1'b0;
      core_in_valid <= 1'b0;
      tot_valid     <= 1'b0;
      // Registered from next state so selling rises with the first OPEN cycle.
      core_selling  <= (state_nx == OPEN) || (state_nx == ISSUE) || (state_nx == WAIT_RSP);

      if (state == DONE)                    close_pend <= 1'b0;
      else if (close_req && state != IDLE)  close_pend <= 1'b1;

      if ((state == WAIT_RSP || state == CLOSE) && state_nx == state) cnt <= cnt + 1'b1;
      else                                                             cnt <= '0;

      if (take_grant) begin
        ptr             <= grant_idx;
        core_in_valid   <= 1'b1;
        core_ramen_type <= req_type[{grant_idx, 1'b0} +: 2];
        core_portion    <= req_portion[grant_idx];
      end

      if (state == WAIT_RSP && state_nx == OPEN) begin
        rsp_valid[ptr] <= 1'b1;
        rsp_success    <= core_out_valid_order & core_success;
        if (!core_out_valid_order) timeout_err <= 1'b1;
      end

      if (state == CLOSE && state_nx == DONE) begin
        tot_valid <= 1'b1;
        if (core_out_valid_tot) begin
          tot_gain <= core_total_gain;
          tot_sold <= core_sold_num;
        end else begin
          tot_gain    <= '0;
          tot_sold    <= '0;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ramen_order_sched.sv
// Bench for ramen_order_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a session-level reference model.
module tb_ramen_order_sched;

  localparam int N  = 4;
  localparam int TO = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, open_req, close_req;
  logic [N-1:0]   req_valid, req_portion;
  logic [2*N-1:0] req_type;
  logic           core_out_valid_order, core_success, core_out_valid_tot;
  logic [14:0]    core_total_gain;
  logic [27:0]    core_sold_num;
  logic [N-1:0]   req_ready, rsp_valid;
  logic           rsp_success, core_in_valid, core_selling, core_portion;
  logic [1:0]     core_ramen_type;
  logic           tot_valid, busy, timeout_err;
  logic [14:0]    tot_gain;
  logic [27:0]    tot_sold;

  ramen_order_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .open_req(open_req), .close_req(close_req),
    .req_valid(req_valid), .req_type(req_type), .req_portion(req_portion),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_success(rsp_success),
    .core_in_valid(core_in_valid), .core_selling(core_selling),
    .core_portion(core_portion), .core_ramen_type(core_ramen_type),
    .core_out_valid_order(core_out_valid_order), .core_success(core_success),
    .core_out_valid_tot(core_out_valid_tot), .core_total_gain(core_total_gain),
    .core_sold_num(core_sold_num), .tot_valid(tot_valid), .tot_gain(tot_gain),
    .tot_sold(tot_sold), .busy(busy), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_OPEN, M_ISSUE, M_WAIT, M_CLOSE, M_DONE} mode_t;
  typedef struct packed {
    logic [N-1:0] rsp_valid;
    logic         rsp_success, civ, sell, portion, tot_valid, terr;
    logic [1:0]   typ;
    logic [14:0]  gain;
    logic [27:0]  sold;
  } exp_t;

  mode_t  ms   = M_IDLE;
  bit     pend = 1'b0;
  int     last = N - 1;
  longint cyc  = 0;
  longint t0   = 0;
  exp_t   e    = '0;

  function automatic int pick(input logic [N-1:0] v, input int from);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = v >> ((from + k) % N);
      if (s[0]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(req_valid, last);
    if (ms == M_OPEN && !pend && g >= 0) return {{(N-1){1'b0}}, 1'b1} << g;
    return '0;
  endfunction

  always @(posedge clk) begin : model
    mode_t          nx;
    exp_t           n;
    int             g, n_last;
    bit             n_pend;
    longint         c, n_t0;
    logic [2*N-1:0] ts;
    logic [N-1:0]   ps;
    if (!rst_n) begin
      ms   <= M_IDLE;
      pend <= 1'b0;
      last <= N - 1;
      e    <= '0;
    end else begin
      c = cyc + 1; nx = ms; n = e; n_last = last; n_t0 = t0; n_pend = pend;
      n.rsp_valid = '0; n.rsp_success = 1'b0; n.civ = 1'b0; n.tot_valid = 1'b0;
      case (ms)
        M_IDLE: if (open_req) nx = M_OPEN;
        M_OPEN: begin
          g = pick(req_valid, last);
          if (pend) begin
            nx = M_CLOSE; n_t0 = c;
          end else if (g >= 0) begin
            n_last = g;
            ts = req_type >> (2 * g);
            ps = req_portion >> g;
            n.typ = ts[1:0]; n.portion = ps[0]; n.civ = 1'b1;
            nx = M_ISSUE;
          end
        end
        M_ISSUE: begin nx = M_WAIT; n_t0 = c; end
        M_WAIT: if (core_out_valid_order || (c - t0) == TO) begin
          n.rsp_valid   = {{(N-1){1'b0}}, 1'b1} << last;
          n.rsp_success = core_out_valid_order & core_success;
          if (!core_out_valid_order) n.terr = 1'b1;
          nx = M_OPEN;
        end
        M_CLOSE: if (core_out_valid_tot || (c - t0) == TO) begin
          n.tot_valid = 1'b1;
          if (core_out_valid_tot) begin
            n.gain = core_total_gain; n.sold = core_sold_num;
          end else begin
            n.gain = '0; n.sold = '0; n.terr = 1'b1;
          end
          nx = M_DONE;
        end
        M_DONE: nx = M_IDLE;
        default: nx = M_IDLE;
      endcase
      if (ms == M_DONE) n_pend = 1'b0;
      else if (close_req && ms != M_IDLE) n_pend = 1'b1;
      n.sell = (nx == M_OPEN) || (nx == M_ISSUE) || (nx == M_WAIT);
      cyc  <= c;
      t0   <= n_t0;
      last <= n_last;
      pend <= n_pend;
      ms   <= nx;
      e    <= n;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      check("rsp_valid",       rsp_valid,       e.rsp_valid);
      check("rsp_success",     rsp_success,     e.rsp_success);
      check("core_in_valid",   core_in_valid,   e.civ);
      check("core_selling",    core_selling,    e.sell);
      check("core_portion",    core_portion,    e.portion);
      check("core_ramen_type", core_ramen_type, e.typ);
      check("tot_valid",       tot_valid,       e.tot_valid);
      check("tot_gain",        tot_gain,        e.gain);
      check("tot_sold",        tot_sold,        e.sold);
      check("timeout_err",     timeout_err,     e.terr);
      check("req_ready",       req_ready,       exp_ready());
      check("busy",            busy,            ms != M_IDLE);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
    open_req = 1'b0; close_req = 1'b0;
    core_out_valid_order = 1'b0; core_out_valid_tot = 1'b0;
  endtask

  int n, ng;
  int grants[5];
  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; open_req = 1'b0; close_req = 1'b0;
    req_valid = '0; req_type = '0; req_portion = '0;
    core_out_valid_order = 1'b0; core_success = 1'b0; core_out_valid_tot = 1'b0;
    core_total_gain = '0; core_sold_num = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    #1;
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_selling", core_selling, 1'b0);
    check("reset_terr", timeout_err, 1'b0);
    check("reset_tot", {tot_valid, tot_gain, tot_sold}, '0);

    // close in IDLE is ignored, then a basic order on window 2
    nxt(); close_req = 1'b1;
    nxt(); #1 check("idle_close_ignored", busy, 1'b0);
    open_req = 1'b1;
    nxt(); req_valid = 4'b0100; req_type = 8'b00_01_00_00; req_portion = 4'b0100;
    #1 check("basic_ready", req_ready, 4'b0100);
    check("open_selling", core_selling, 1'b1);
    nxt(); req_valid = '0;
    #1 check("basic_civ", core_in_valid, 1'b1);
    check("basic_type", core_ramen_type, 2'd1);
    check("basic_portion", core_portion, 1'b1);
    nxt(); core_out_valid_order = 1'b1; core_success = 1'b1;
    nxt(); #1 check("basic_rsp", rsp_valid, 4'b0100);
    check("basic_success", rsp_success, 1'b1);

    // open_req and core response while OPEN are ignored
    open_req = 1'b1; core_out_valid_order = 1'b1;
    nxt(); #1 check("spurious_rsp", rsp_valid, '0);
    check("spurious_busy", busy, 1'b1);

    // order on window 1 that the core never answers
    req_valid = 4'b0010; req_type = 8'b00_00_11_00; req_portion = 4'b0000;
    #1 check("to_ready", req_ready, 4'b0010);
    nxt(); req_valid = '0;
    n = 0;
    do begin nxt(); #1; n++; end while (rsp_valid == '0 && n < TO + 8);
    check("to_latency", n, TO + 1);
    check("to_rsp", rsp_valid, 4'b0010);
    check("to_success", rsp_success, 1'b0);
    check("to_err", timeout_err, 1'b1);

    // close requested while an order is in flight
    nxt(); req_valid = 4'b1000;
    #1 check("close_ready", req_ready, 4'b1000);
    nxt(); req_valid = '0;
    nxt(); close_req = 1'b1;
    nxt(); core_out_valid_order = 1'b1; core_success = 1'b1;
    nxt(); req_valid = 4'b0001;
    #1 check("close_rsp_first", rsp_valid, 4'b1000);
    check("close_still_selling", core_selling, 1'b1);
    check("close_no_accept", req_ready, '0);
    nxt(); req_valid = '0; core_out_valid_tot = 1'b1;
    core_total_gain = 15'd1234; core_sold_num = 28'h0010203;
    #1 check("close_selling_off", core_selling, 1'b0);
    nxt(); #1 check("tot_valid", tot_valid, 1'b1);
    check("tot_gain", tot_gain, 15'd1234);
    check("tot_sold", tot_sold, 28'h0010203);
    check("done_busy", busy, 1'b1);
    check("terr_sticky", timeout_err, 1'b1);
    nxt(); #1 check("idle_busy", busy, 1'b0);
    check("tot_hold", tot_gain, 15'd1234);

    // reset while waiting for a response
    nxt(); open_req = 1'b1;
    nxt(); req_valid = 4'b0100;
    nxt(); req_valid = '0;
    nxt(); rst_n = 1'b0; core_out_valid_order = 1'b1; core_success = 1'b1;
    nxt(); rst_n = 1'b1;
    #1 check("rst_rsp", rsp_valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_outs", {core_in_valid, core_selling, core_ramen_type, tot_gain, tot_sold}, '0);
    nxt(); #1 check("rst_no_late_rsp", rsp_valid, '0);

    // fairness with all windows requesting continuously
    open_req = 1'b1;
    nxt(); req_valid = '1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      core_out_valid_order = 1'b1; core_success = 1'($urandom);
      #1;
      if (req_ready != '0) begin grants[ng] = $clog2(req_ready); ng++; end
      if (ng < 5) nxt();
    end
    check("fair_count", ng, 5);
    for (int i = 0; i < 5; i++) check($sformatf("fair_grant%0d", i), grants[i], exp_g[i]);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst_n     = ($urandom_range(0, 399) != 0);
      open_req  = ($urandom_range(0, 7) == 0);
      close_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0) req_valid = N'($urandom);
      req_type             = (2*N)'($urandom);
      req_portion          = N'($urandom);
      core_out_valid_order = ($urandom_range(0, 4) == 0);
      core_success         = 1'($urandom);
      core_out_valid_tot   = ($urandom_range(0, 5) == 0);
      core_total_gain      = 15'($urandom);
      core_sold_num        = 28'($urandom);
    end
    nxt(); rst_n = 1'b1;
    repeat (3) nxt();
    chk_en = 1'b0;
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ramen_order_sched.md
Name: ramen_order_sched

Overview:
- Front-end scheduler for the Ramen kitchen core. Collects orders from N_REQ ordering windows and arbitrates them round-robin onto the core's single order port, one order in flight at a time.
- Opens and closes the selling session, routes each core order response back to the originating window, and captures the end-of-session totals.

Parameters:
N_REQ, 4, number of ordering windows (2..8)
TIMEOUT, 1023, max cycles waiting for any core response (order or totals)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
open_req  in  1  pulse: start selling session
close_req  in  1  pulse: end selling session
req_valid  in  N_REQ  per-window order valid
req_type  in  2*N_REQ  per-window ramen type, window i at [2i+1:2i]
req_portion  in  N_REQ  per-window portion
req_ready  out  N_REQ  one-hot accept; handshake = valid & ready
rsp_valid  out  N_REQ  one-hot 1-cycle response pulse
rsp_success  out  1  order result, valid with rsp_valid
core_in_valid  out  1  to core in_valid
core_selling  out  1  to core selling
core_portion  out  1  to core portion
core_ramen_type  out  2  to core ramen_type
core_out_valid_order  in  1  from core
core_success  in  1  from core
core_out_valid_tot  in  1  from core
core_total_gain  in  15  from core
core_sold_num  in  28  from core
tot_valid  out  1  1-cycle pulse: session totals valid
tot_gain  out  15  captured total gain
tot_sold  out  28  captured sold counts
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge) clears all registers and outputs to 0, sets state to IDLE, clears the pending-close flag, and sets the RR pointer to N_REQ-1 so window 0 has first priority.
- Reset applied mid-operation abandons any in-flight order. No rsp_valid is issued for it.
- Outputs req_ready and busy are combinational from state. All other outputs are registered.
- FSM states: IDLE, OPEN, ISSUE, WAIT_RSP, CLOSE, DONE.
- IDLE:
  - core_selling=0.
  - open_req goes to OPEN. close_req is ignored. If open_req and close_req arrive together, the session opens and the close is dropped.
- OPEN:
  - core_selling=1 from the first OPEN cycle through the last pre-CLOSE cycle.
  - If close_pend=1, go to CLOSE.
  - Else, if any req_valid is set, grant window g, the first set bit searching from ptr+1 mod N_REQ upward. Assert req_ready[g] this cycle, capture req_type[g] and req_portion[g], set ptr=g, and go to ISSUE.
- ISSUE:
  - core_in_valid=1 for exactly one cycle, with the captured type and portion on core_ramen_type and core_portion.
  - Go to WAIT_RSP.
  - core_ramen_type and core_portion hold their values until the next issue.
- WAIT_RSP:
  - Counter increments each cycle.
  - On core_out_valid_order: the next cycle pulses rsp_valid[g]=1 with rsp_success=core_success, and the state returns to OPEN.
  - If the counter reaches TIMEOUT first: pulse rsp_valid[g] with rsp_success=0, set timeout_err, and return to OPEN.
  - Counter clears on exit.
- close_req:
  - In any non-IDLE state, close_req sets close_pend.
  - An in-flight order always completes before CLOSE is entered.
  - Orders not yet granted are not accepted once close_pend=1.
- CLOSE:
  - core_selling=0 and req_ready=0.
  - On core_out_valid_tot: capture core_total_gain and core_sold_num, then go to DONE.
  - On TIMEOUT: capture zeros, set timeout_err, and go to DONE.
- DONE:
  - tot_valid=1 for one cycle with tot_gain and tot_sold.
  - Clear close_pend and go to IDLE.
  - tot_gain and tot_sold hold their values until the next capture.
- Spurious inputs are ignored:
  - core_out_valid_order outside WAIT_RSP.
  - core_out_valid_tot outside CLOSE.
  - open_req outside IDLE.
- Latency:
  - Accept to core_in_valid: 1 cycle.
  - core_out_valid_order to rsp_valid: 1 cycle.
  - core_out_valid_tot to tot_valid: 1 cycle.
- Throughput: at most one order per 3 + core-latency cycles. The RR pointer wraps from N_REQ-1 to 0.

Test Plan:
- Basic order: open_req, then window 2 requests type=1, portion=1 -> req_ready=4'b0100 in the same cycle; next cycle core_in_valid=1, type=1, portion=1; core answers success=1 -> next cycle rsp_valid=4'b0100, rsp_success=1.
- Fairness: all 4 windows hold valid continuously -> grant order 0,1,2,3,0, with no window granted twice before the others are served.
- Close during in-flight order: close_req in WAIT_RSP -> order response is delivered first, then core_selling=0; core tot gain=15'd1234, sold=28'h0010203 -> one cycle later tot_valid=1 with those values, busy=0 the following cycle.
- Timeout: core never answers the order -> after TIMEOUT cycles rsp_valid with rsp_success=0 and timeout_err=1; timeout_err stays 1 through a later normal session until rst_n=0.
- Reset mid-WAIT_RSP: rst_n low for 1 cycle -> all outputs 0, no rsp_valid; next open_req grants window 0 first.
- Ignored events: close_req in IDLE and open_req in OPEN -> no state change; spurious core_out_valid_order in OPEN -> no rsp_valid.
